rs_issue_arbiter: RTL and testbench
===================================

// Module: rs_issue_arbiter
// PURPOSE
// - Issue scheduler between the ALU reservation station and its two execute units: ALU (acu=0) and CMP/ACU (acu=1).
// - Each cycle picks at most one ready RS entry per unit, round-robin, and holds it in a registered issue slot.
// - Uses a valid/ready handshake to each unit.
// - Tracks in-flight entries so an entry is never issued twice before its broadcast frees it.
// PARAMETERS
// - SIZE   8                 number of RS entries; power of 2
// - IDX_W  $clog2(SIZE) = 3  RS index width
// PORTS
// - clk              in   1      single clock; all state on posedge
// - rst_n            in   1      reset, asynchronous, active-low
// - flush_valid      in   1      pipeline flush; kills pending issues
// - rs_ready         in   SIZE   RS entry valid and both operands resolved
// - rs_acu           in   SIZE   entry targets CMP unit (1) or ALU (0)
// - rs_clear         in   SIZE   entry freed by result broadcast this cycle
// - alu_issue_valid  out  1      ALU slot holds an entry
// - alu_issue_idx    out  IDX_W  RS index in ALU slot
// - alu_issue_ready  in   1      ALU accepts the slot this cycle
// - cmp_issue_valid  out  1      CMP slot holds an entry
// - cmp_issue_idx    out  IDX_W  RS index in CMP slot
// - cmp_issue_ready  in   1      CMP accepts the slot this cycle
// - issued_mask      out  SIZE   entries issued and not yet cleared
// BEHAVIOUR
// - Reset (rst_n=0, async): *_issue_valid=0, *_issue_idx=0, issued_mask=0, both rr pointers=0. Perf counters=0 when compiled in.
// - Candidates per unit: rs_ready[i] & ~issued_mask[i] & ~rs_clear[i] & (rs_acu[i] matches the unit).
// - Slot is free when valid=0 or (valid & ready) this cycle. Only a free slot loads a new grant.
// - Grant: first candidate scanning rr_ptr, rr_ptr+1, ... mod SIZE (wraps past SIZE-1 to 0).
//   - On grant i: slot valid<=1, idx<=i, issued_mask[i]<=1, rr_ptr<=(i+1) mod SIZE.
//   - With no candidate: valid<=0 if the slot was accepted, else it holds.
// - Latency: rs_ready rising in cycle N gives *_issue_valid=1 in cycle N+1.
//   - Accept plus new grant in the same cycle gives back-to-back issue, one entry per unit per cycle.
// - Handshake: while valid & ~ready, idx and valid are held stable. valid never drops without ready, except on flush or rs_clear.
// - Accepted entries stay set in issued_mask until rs_clear[i]. rs_clear[i] clears issued_mask[i] next cycle.
// - rs_clear[idx] of a pending, unaccepted slot drops that slot (valid<=0) next cycle. No grant that cycle for the entry.
// - ALU and CMP arbitrate independently. The same index can never appear in both slots, since rs_acu partitions them.
// - Flush (priority over grant, accept and clear):
//   - both valid<=0 and issued_mask<=0 next cycle.
//   - rr pointers are kept.
//   - No grant is made in the flush cycle.
// - rst_n asserted mid-handshake: the slot is dropped immediately. The unit must ignore an accept in that cycle.
// - All index arithmetic is modulo SIZE at IDX_W bits. No state beyond the slots, the mask and the pointers.
// CONFIGURATION
// - Macro RS_ISSUE_PERF_EN.
// - Defined: adds outputs alu_issue_cnt[31:0], cmp_issue_cnt[31:0] and stall_cnt[31:0].
//   - The issue counters increment on each valid&ready of their unit.
//   - stall_cnt increments each cycle either slot has valid&~ready.
//   - All three saturate at 32'hFFFF_FFFF, reset to 0 and are not cleared by flush.
// - Undefined: these ports and their logic are absent. Core behaviour is identical.
// TESTING
// - Reset: rst_n=0 while alu_issue_valid=1 -> all outputs 0 asynchronously; stay 0 until release.
// - RR/wrap: rs_ready=8'h24, rs_acu=0, alu_ready=1 held -> alu_issue_idx 2 then 5; rs_ready=8'h01 after -> idx 0 (rr_ptr wrapped from 6).
// - Dual issue: rs_ready=8'h03, rs_acu=8'h02 -> in the same cycle alu_idx=0 and cmp_idx=1 both valid; issued_mask=8'h03.
// - Backpressure: alu_issue_ready=0 for 3 cycles with rs_ready=8'h0C -> idx 2 held 3 cycles, entry 3 not issued; ready=1 -> idx 3 next cycle.
// - Flush: flush_valid=1 with both slots pending, issued_mask=8'h11 -> next cycle both valid=0, mask=0, no grant that cycle.
// - Clear: rs_clear[2]=1 while issued_mask[2]=1 -> mask bit 0 next cycle; with rs_ready[2]=1 again, entry 2 reissued.

Source files
------------

// File: rtl/rs_issue_arbiter.sv
// rs_issue_arbiter
//   Issue scheduler between the ALU reservation station and its two execute
//   units: ALU (rs_acu=0, unit 0) and CMP/ACU (rs_acu=1, unit 1). Each cycle
//   every unit whose registered issue slot is free picks one ready RS entry
//   round-robin and loads it into the slot. It then holds the slot under a
//   valid/ready handshake. issued_mask tracks entries from grant until their
//   result broadcast (rs_clear), so that no entry is issued twice.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   flush_valid                 kills both slots and the in-flight mask
//   rs_ready/rs_acu/rs_clear    per-entry ready, unit select, broadcast free
//   alu_issue_valid/idx/ready   ALU issue slot handshake
//   cmp_issue_valid/idx/ready   CMP issue slot handshake
//   issued_mask                 entries issued and not yet cleared
//
// Configuration
//   RS_ISSUE_PERF_EN  adds the saturating counters alu_issue_cnt,
//                     cmp_issue_cnt and stall_cnt
module rs_issue_arbiter #(
    parameter  int unsigned SIZE  = 8,
    localparam int unsigned IDX_W = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_valid,
    input  logic [SIZE-1:0]  rs_ready,
    input  logic [SIZE-1:0]  rs_acu,
    input  logic [SIZE-1:0]  rs_clear,
    output logic             alu_issue_valid,
    output logic [IDX_W-1:0] alu_issue_idx,
    input  logic             alu_issue_ready,
    output logic             cmp_issue_valid,
    output logic [IDX_W-1:0] cmp_issue_idx,
    input  logic             cmp_issue_ready,
    output logic [SIZE-1:0]  issued_mask
`ifdef RS_ISSUE_PERF_EN
    ,
    output logic [31:0]      alu_issue_cnt,
    output logic [31:0]      cmp_issue_cnt,
    output logic [31:0]      stall_cnt
`endif
);

    localparam int unsigned NU = 2;

    // Slot state per unit (0 = ALU, 1 = CMP), shared in-flight mask
    logic [NU-1:0]    r_valid;
    logic [IDX_W-1:0] r_idx [NU];
    logic [IDX_W-1:0] r_ptr [NU];
    logic [SIZE-1:0]  r_mask;

    logic [NU-1:0]    w_ready;
    logic [NU-1:0]    w_free;
    logic [NU-1:0]    w_drop;
    logic [NU-1:0]    w_found;
    logic [IDX_W-1:0] w_gnt [NU];
    logic [SIZE-1:0]  w_cand [NU];
    logic [SIZE-1:0]  w_gnt_mask;

    // Candidate selection and round-robin grant for both units
    always_comb begin
        w_ready    = {cmp_issue_ready, alu_issue_ready};
        w_gnt_mask = '0;
        for (int u = 0; u < NU; u++) begin
            w_cand[u]  = rs_ready & ~r_mask & ~rs_clear & ((u == 0) ? ~rs_acu : rs_acu);
            w_free[u]  = ~r_valid[u] | w_ready[u];
            // A stalled slot whose entry got broadcast-freed is withdrawn
            w_drop[u]  = r_valid[u] & ~w_ready[u] & rs_clear[r_idx[u]];
            w_found[u] = 1'b0;
            w_gnt[u]   = '0;
            // Scan from the pointer; the IDX_W-bit sum wraps modulo SIZE
            for (int k = 0; k < int'(SIZE); k++) begin
                if (!w_found[u] && w_cand[u][r_ptr[u] + IDX_W'(k)]) begin
                    w_found[u] = 1'b1;
                    w_gnt[u]   = r_ptr[u] + IDX_W'(k);
                end
            end
            if (w_free[u] && w_found[u]) begin
                w_gnt_mask[w_gnt[u]] = 1'b1;
            end
        end
    end

    // Slot, pointer and in-flight mask registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_mask  <= '0;
            for (int u = 0; u < NU; u++) begin
                r_idx[u] <= '0;
                r_ptr[u] <= '0;
            end
        end else if (flush_valid) begin
            // Flush wins over grant, accept and clear; pointers are kept
            r_valid <= '0;
            r_mask  <= '0;
        end else begin
            r_mask <= (r_mask & ~rs_clear) | w_gnt_mask;
            for (int u = 0; u < NU; u++) begin
                if (w_free[u] && w_found[u]) begin
                    r_valid[u] <= 1'b1;
                    r_idx[u]   <= w_gnt[u];
                    r_ptr[u]   <= w_gnt[u] + IDX_W'(1);
                end else if (w_free[u] || w_drop[u]) begin
                    r_valid[u] <= 1'b0;
                end
            end
        end
    end

    assign alu_issue_valid = r_valid[0];
    assign alu_issue_idx   = r_idx[0];
    assign cmp_issue_valid = r_valid[1];
    assign cmp_issue_idx   = r_idx[1];
    assign issued_mask     = r_mask;

`ifdef RS_ISSUE_PERF_EN
    logic [31:0] r_alu_cnt;
    logic [31:0] r_cmp_cnt;
    logic [31:0] r_stall_cnt;

    // Saturating performance counters; flush does not clear them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_cnt   <= '0;
            r_cmp_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_valid[0] && alu_issue_ready && !(&r_alu_cnt)) begin
                r_alu_cnt <= r_alu_cnt + 32'd1;
            end
            if (r_valid[1] && cmp_issue_ready && !(&r_cmp_cnt)) begin
                r_cmp_cnt <= r_cmp_cnt + 32'd1;
            end
            if ((|(r_valid & ~w_ready)) && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign alu_issue_cnt = r_alu_cnt;
    assign cmp_issue_cnt = r_cmp_cnt;
    assign stall_cnt     = r_stall_cnt;
`endif

endmodule

// File: tb/tb_rs_issue_arbiter.sv
// Bench for rs_issue_arbiter: directed scenarios plus random traffic.
// The driver steps a behavioural model after each stimulus and queues the
// expected outputs. A monitor checks them after the following clock edge.
`timescale 1ns/1ps
module tb_rs_issue_arbiter;

    localparam int unsigned SIZE  = 8;
    localparam int unsigned IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush_valid = 1'b0;
    logic [SIZE-1:0]  rs_ready = '0;
    logic [SIZE-1:0]  rs_acu = '0;
    logic [SIZE-1:0]  rs_clear = '0;
    logic             alu_issue_valid;
    logic [IDX_W-1:0] alu_issue_idx;
    logic             alu_issue_ready = 1'b0;
    logic             cmp_issue_valid;
    logic [IDX_W-1:0] cmp_issue_idx;
    logic             cmp_issue_ready = 1'b0;
    logic [SIZE-1:0]  issued_mask;
`ifdef RS_ISSUE_PERF_EN
    logic [31:0]      alu_issue_cnt;
    logic [31:0]      cmp_issue_cnt;
    logic [31:0]      stall_cnt;
`endif

    rs_issue_arbiter #(.SIZE(SIZE)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_valid     (flush_valid),
        .rs_ready        (rs_ready),
        .rs_acu          (rs_acu),
        .rs_clear        (rs_clear),
        .alu_issue_valid (alu_issue_valid),
        .alu_issue_idx   (alu_issue_idx),
        .alu_issue_ready (alu_issue_ready),
        .cmp_issue_valid (cmp_issue_valid),
        .cmp_issue_idx   (cmp_issue_idx),
        .cmp_issue_ready (cmp_issue_ready),
        .issued_mask     (issued_mask)
`ifdef RS_ISSUE_PERF_EN
        ,
        .alu_issue_cnt   (alu_issue_cnt),
        .cmp_issue_cnt   (cmp_issue_cnt),
        .stall_cnt       (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  v;
        logic [2:0]  idx0;
        logic [2:0]  idx1;
        logic [7:0]  mask;
        logic [31:0] acnt;
        logic [31:0] ccnt;
        logic [31:0] scnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    bit       m_valid [2];
    int       m_idx   [2];
    int       m_ptr   [2];
    bit [7:0] m_mask;
    int unsigned m_cnt [2];
    int unsigned m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int u = 0; u < 2; u++) begin
            m_valid[u] = 1'b0;
            m_idx[u]   = 0;
            m_ptr[u]   = 0;
            m_cnt[u]   = 0;
        end
        m_mask  = '0;
        m_stall = 0;
    endfunction

    // One clock edge of the arbiter, computed from the rules directly
    function automatic void model_step();
        bit [7:0] nmask;
        bit [1:0] rdy;
        int pick;
        int e;
        rdy = {cmp_issue_ready, alu_issue_ready};
        for (int u = 0; u < 2; u++)
            if (m_valid[u] && rdy[u] && m_cnt[u] != 32'hFFFF_FFFF) m_cnt[u]++;
        if (((m_valid[0] && !rdy[0]) || (m_valid[1] && !rdy[1])) && m_stall != 32'hFFFF_FFFF)
            m_stall++;
        if (flush_valid) begin
            m_valid[0] = 1'b0;
            m_valid[1] = 1'b0;
            m_mask     = '0;
            return;
        end
        nmask = m_mask & ~rs_clear;
        for (int u = 0; u < 2; u++) begin
            if (!m_valid[u] || rdy[u]) begin
                pick = -1;
                for (int k = 0; k < int'(SIZE); k++) begin
                    e = (m_ptr[u] + k) % SIZE;
                    if (pick < 0 && rs_ready[e] && !m_mask[e] && !rs_clear[e] && (int'(rs_acu[e]) == u))
                        pick = e;
                end
                if (pick >= 0) begin
                    m_valid[u]  = 1'b1;
                    m_idx[u]    = pick;
                    nmask[pick] = 1'b1;
                    m_ptr[u]    = (pick + 1) % SIZE;
                end else begin
                    m_valid[u] = 1'b0;
                end
            end else if (rs_clear[m_idx[u]]) begin
                m_valid[u] = 1'b0;
            end
        end
        m_mask = nmask;
    endfunction

    // Drive one cycle of stimulus and queue what the DUT must show after the edge
    task automatic cyc(input logic [7:0] rdy, input logic [7:0] acu, input logic [7:0] clr,
                       input logic fl, input logic ardy, input logic crdy);
        exp_t x;
        @(negedge clk);
        rs_ready        = rdy;
        rs_acu          = acu;
        rs_clear        = clr;
        flush_valid     = fl;
        alu_issue_ready = ardy;
        cmp_issue_ready = crdy;
        model_step();
        x.v    = {m_valid[1], m_valid[0]};
        x.idx0 = 3'(m_idx[0]);
        x.idx1 = 3'(m_idx[1]);
        x.mask = m_mask;
        x.acnt = m_cnt[0];
        x.ccnt = m_cnt[1];
        x.scnt = m_stall;
        exp_q.push_back(x);
    endtask

    task automatic idle_inputs();
        rs_ready        = '0;
        rs_acu          = '0;
        rs_clear        = '0;
        flush_valid     = 1'b0;
        alu_issue_ready = 1'b0;
        cmp_issue_ready = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_alu_valid"}, 32'(alu_issue_valid), 32'd0);
        chk({tag, "_alu_idx"},   32'(alu_issue_idx),   32'd0);
        chk({tag, "_cmp_valid"}, 32'(cmp_issue_valid), 32'd0);
        chk({tag, "_cmp_idx"},   32'(cmp_issue_idx),   32'd0);
        chk({tag, "_mask"},      32'(issued_mask),     32'd0);
    endtask

    // Monitor: compare the queued expectation after every rising edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("alu_valid", 32'(alu_issue_valid), 32'(x.v[0]));
                chk("cmp_valid", 32'(cmp_issue_valid), 32'(x.v[1]));
                if (x.v[0]) chk("alu_idx", 32'(alu_issue_idx), 32'(x.idx0));
                if (x.v[1]) chk("cmp_idx", 32'(cmp_issue_idx), 32'(x.idx1));
                chk("issued_mask", 32'(issued_mask), 32'(x.mask));
`ifdef RS_ISSUE_PERF_EN
                chk("alu_cnt",   alu_issue_cnt, x.acnt);
                chk("cmp_cnt",   cmp_issue_cnt, x.ccnt);
                chk("stall_cnt", stall_cnt,     x.scnt);
`endif
            end
        end
    end

    initial begin
        model_reset();
        idle_inputs();
        #12;
        chk_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin with wrap: 2, then 5, then 0 once the pointer sits at 6
        cyc(8'h24, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        cyc(8'h24, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        cyc(8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        cyc(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        cyc(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);

        // Dual issue: ALU takes 0, CMP takes 1 in the same cycle
        cyc(8'h03, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(8'h03, 8'h02, 8'h00, 1'b0, 1'b1, 1'b1);
        cyc(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);

        // Backpressure: idx 2 held while stalled, then 3
        for (int i = 0; i < 4; i++) cyc(8'h0C, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(8'h0C, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        cyc(8'h0C, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        cyc(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);

        // Flush with both slots pending and mask 8'h11
        cyc(8'h11, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(8'h11, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(8'h11, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);

        // Clear then reissue of entry 2
        cyc(8'h04, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        cyc(8'h04, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        cyc(8'h04, 8'h00, 8'h04, 1'b0, 1'b1, 1'b1);
        cyc(8'h04, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        // Clear of a stalled slot drops it
        cyc(8'h00, 8'h00, 8'h04, 1'b0, 1'b1, 1'b1);
        cyc(8'h20, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(8'h20, 8'h00, 8'h20, 1'b0, 1'b0, 1'b0);
        cyc(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while the ALU slot is pending
        cyc(8'h08, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        chk("pre_reset_alu_valid", 32'(alu_issue_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(8'($urandom), 8'($urandom), 8'($urandom & $urandom & $urandom),
                ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) != 0));
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
